// File: rtl/mant_inc_arbiter_pkg.sv
// Shared widths and output-stage state type for the mantissa increment arbiter.
package mant_arb_pkg;
  localparam int MANT_W = 53;
  localparam int INC_W  = 4;
  localparam int SUM_W  = 54;
  localparam int CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;
endpackage

// File: rtl/customAdder53_49.sv
// Shared mantissa increment adder: 53-bit operand plus zero-extended 4-bit increment.
module customAdder53_49
  import mant_arb_pkg::*;
(
  input  logic [MANT_W-1:0] A,
  input  logic [INC_W-1:0]  B,
  output logic [SUM_W-1:0]  S
);
  assign S = {1'b0, A} + {{(SUM_W-INC_W){1'b0}}, B};
endmodule

// File: rtl/mant_inc_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);
  localparam int unsigned N = NUM_REQ;

  always_comb begin
    logic             found;
    logic [ID_W-1:0]  j_idx;
    int unsigned      j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    j_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j     = (32'(ptr_i) + k) % N;
      j_idx = ID_W'(j);
      if (!found && req_i[j_idx]) begin
        found          = 1'b1;
        idx_o          = j_idx;
        grant_o[j_idx] = en_i;
      end
    end
  end
endmodule

// File: rtl/mant_inc_arbiter.sv
// Round-robin sharing of one mantissa increment adder with a one-entry output register.
// Optional carry-out counter enabled by defining MANT_ARB_CARRY_CNT_EN.
module mant_inc_arbiter
  import mant_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*MANT_W-1:0] req_a,
  input  logic [NUM_REQ*INC_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [SUM_W-1:0]          rsp_sum,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready
`ifdef MANT_ARB_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0]          carry_cnt
`endif
);
  out_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] grant;
  logic              can_issue, xfer;
  logic [MANT_W-1:0] op_a;
  logic [INC_W-1:0]  op_b;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_q;
  logic [ID_W-1:0]   id_q;

  // rst_n gates the grant so req_ready stays low for the whole reset assertion.
  assign can_issue = rst_n && ((state_q == EMPTY) || rsp_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (can_issue),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  assign xfer      = |grant;
  assign req_ready = grant;
  assign op_a      = req_a[int'(win_idx)*MANT_W +: MANT_W];
  assign op_b      = req_b[int'(win_idx)*INC_W +: INC_W];

  customAdder53_49 u_add (
    .A (op_a),
    .B (op_b),
    .S (sum)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = FULL;
      ptr_d   = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + ID_W'(1);
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        sum_q <= sum;
        id_q  <= win_idx;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

`ifdef MANT_ARB_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (xfer && sum[SUM_W-1] && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign carry_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_mant_inc_arbiter.sv
// Scoreboard bench for mant_inc_arbiter; carry counter checked when MANT_ARB_CARRY_CNT_EN is defined.
module tb_mant_inc_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    int          id;
    logic [53:0] sum;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*53-1:0] req_a;
  logic [N*4-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [53:0]     rsp_sum;
  logic [IW-1:0]   rsp_id;
  logic            rsp_ready;
`ifdef MANT_ARB_CARRY_CNT_EN
  logic [15:0]     carry_cnt;
`endif

  logic [52:0] a_m [N];
  logic [3:0]  b_m [N];

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];
  int   m_ptr;
  bit   m_full;
  int   m_cnt;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*53 +: 53] = a_m[i];
      req_b[i*4 +: 4]   = b_m[i];
    end
  end

  mant_inc_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef MANT_ARB_CARRY_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Output monitor: pops the scoreboard on each accepted result, checks stability under stall.
  bit          held;
  logic [53:0] held_sum;
  logic [IW-1:0] held_id;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (!rsp_valid || rsp_sum !== held_sum || rsp_id !== held_id) begin
          fails++;
          $display("FAIL hold: valid=%0b sum=%h id=%0d required valid=1 sum=%h id=%0d",
                   rsp_valid, rsp_sum, rsp_id, held_sum, held_id);
        end
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: sum=%h id=%0d with empty scoreboard", rsp_sum, rsp_id);
        end else begin
          e = exp_q.pop_front();
          if (rsp_sum !== e.sum || int'(rsp_id) != e.id) begin
            fails++;
            $display("FAIL rsp: sum=%h id=%0d required sum=%h id=%0d", rsp_sum, rsp_id, e.sum, e.id);
          end
        end
      end
      held     = rsp_valid && !rsp_ready;
      held_sum = rsp_sum;
      held_id  = rsp_id;
    end
  end

  task automatic step(input logic [N-1:0] v, input logic rr);
    int         w;
    logic [N-1:0] er;
    exp_t       e;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    w  = (!m_full || rr) ? pick(v, m_ptr) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    tests++;
    if (req_ready !== er) begin
      fails++;
      $display("FAIL req_ready: got %b required %b (valid=%b ptr=%0d)", req_ready, er, v, m_ptr);
    end
`ifdef MANT_ARB_CARRY_CNT_EN
    tests++;
    if (int'(carry_cnt) != m_cnt) begin
      fails++;
      $display("FAIL carry_cnt: got %0d required %0d", carry_cnt, m_cnt);
    end
`endif
    if (w >= 0) begin
      e.id  = w;
      e.sum = 54'(a_m[w]) + 54'(b_m[w]);
      exp_q.push_back(e);
      if (e.sum[53] && m_cnt < 65535) m_cnt++;
      m_ptr = (w + 1) % N;
    end
    m_full = (w >= 0) || (m_full && !rr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== '0 || req_ready !== '0) begin
      fails++;
      $display("FAIL %s: valid=%0b sum=%h id=%0d ready=%b required all zero",
               tag, rsp_valid, rsp_sum, rsp_id, req_ready);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       a_m[i] = '1;
        1:       a_m[i] = 53'h1F_FFFF_FFFF_FFF0 | 53'($urandom_range(0, 15));
        default: a_m[i] = 53'({$urandom(), $urandom()});
      endcase
      b_m[i] = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request with carry-out
    a_m[0] = '1; b_m[0] = 4'h1;
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);

    // Boundary arithmetic
    a_m[1] = '0; b_m[1] = 4'hF;
    a_m[2] = 53'h1F_FFFF_FFFF_FFF0; b_m[2] = 4'hF;
    step(4'b0010, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    // Pointer wrap / skip: ptr is 3 here
    a_m[3] = 53'h123_4567; b_m[3] = 4'h7;
    step(4'b0010, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);

    // Round-robin fairness over 8 transfers
    randomize_ops();
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Backpressure: fill, stall 3 cycles with requesters 1 and 2 valid, then drain
    step(4'b0001, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0110, 1'b0);
    step(4'b0110, 1'b1);
    step(4'b0000, 1'b1);

    // Reset mid-operation while FULL
    step(4'b0100, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b1110, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      randomize_ops();
      step(N'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
